wb_cmd_master: RTL and testbench

//  Single-outstanding Wishbone B4 pipelined bus master; sits directly upstream of the WB slave peripherals.

---
 rtl/wb_cmd_master.sv | 192 +++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined master.
// Takes read/write commands on a valid/ready port, runs one bus cycle per
// command, and returns a one-cycle response strobe carrying read data or an
// error/timeout status. A watchdog aborts cycles the slave never completes.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // command port
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [29:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    input  logic [3:0]  i_cmd_sel,
    // wishbone master port
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    // response port
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout
);

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned TMR_W  = 16;

    // Last timer value before the watchdog fires: the cycle is aborted on the
    // edge where TIMEOUT_CYCLES clocks have been spent in REQ/WAIT.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } wb_req_t;

    state_t            state;
    state_t            state_nx;
    wb_req_t           req_q;
    wb_req_t           req_nx;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nx;

    logic              cyc_nx;
    logic              stb_nx;
    logic              ready_nx;
    logic              rsp_valid_nx;
    logic [DATA_W-1:0] rsp_data_nx;
    logic              rsp_err_nx;
    logic              rsp_timeout_nx;

    logic              done_c;
    logic              timeout_c;

    // Slave completion and watchdog expiry as seen on this edge.
    always_comb begin
        done_c    = i_wb_ack | i_wb_err;
        timeout_c = (timer >= TMR_LAST);
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nx       = state;
        req_nx         = req_q;
        timer_nx       = timer;
        cyc_nx         = 1'b0;
        stb_nx         = 1'b0;
        ready_nx       = 1'b0;
        rsp_valid_nx   = 1'b0;
        rsp_data_nx    = DATA_W'(0);
        rsp_err_nx     = 1'b0;
        rsp_timeout_nx = 1'b0;

        case (state)
            S_IDLE: begin
                ready_nx = 1'b1;
                if (i_cmd_valid) begin
                    req_nx.we   = i_cmd_we;
                    req_nx.addr = i_cmd_addr;
                    req_nx.data = i_cmd_data;
                    req_nx.sel  = i_cmd_sel;
                    timer_nx    = TMR_W'(0);
                    cyc_nx      = 1'b1;
                    stb_nx      = 1'b1;
                    ready_nx    = 1'b0;
                    state_nx    = S_REQ;
                end
            end

            S_REQ, S_WAIT: begin
                timer_nx = (timer == {TMR_W{1'b1}}) ? timer : timer + TMR_W'(1);
                cyc_nx   = 1'b1;
                // Strobe stays up only while the slave keeps stalling it.
                stb_nx   = (state == S_REQ) && i_wb_stall;
                state_nx = stb_nx ? S_REQ : S_WAIT;
                if (done_c) begin
                    // Completion beats the watchdog on the same edge; err beats ack.
                    state_nx     = S_RSP;
                    cyc_nx       = 1'b0;
                    stb_nx       = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = i_wb_err;
                    if (!i_wb_err && !req_q.we) begin
                        rsp_data_nx = i_wb_data;
                    end
                end else if (timeout_c) begin
                    state_nx       = S_RSP;
                    cyc_nx         = 1'b0;
                    stb_nx         = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_err_nx     = 1'b1;
                    rsp_timeout_nx = 1'b1;
                end
            end

            S_RSP: begin
                ready_nx = 1'b1;
                state_nx = S_IDLE;
            end

            default: begin
                ready_nx = 1'b1;
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered bus request, watchdog timer and port outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            req_q         <= '0;
            timer         <= TMR_W'(0);
            o_cmd_ready   <= 1'b1;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= DATA_W'(0);
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            req_q         <= req_nx;
            timer         <= timer_nx;
            o_cmd_ready   <= ready_nx;
            o_wb_cyc      <= cyc_nx;
            o_wb_stb      <= stb_nx;
            o_rsp_valid   <= rsp_valid_nx;
            o_rsp_data    <= rsp_data_nx;
            o_rsp_err     <= rsp_err_nx;
            o_rsp_timeout <= rsp_timeout_nx;
        end
    end

    // Bus request fields come straight from the latched command, so they hold
    // for the whole cycle.
    always_comb begin
        o_wb_we   = req_q.we;
        o_wb_addr = req_q.addr;
        o_wb_data = req_q.data;
        o_wb_sel  = req_q.sel;
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master with a scripted Wishbone slave.
module tb_wb_cmd_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_we = 1'b0;
    logic [29:0] i_cmd_addr = '0;
    logic [31:0] i_cmd_data = '0;
    logic [3:0]  i_cmd_sel = '0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err, o_rsp_timeout;

    wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
        .i_cmd_data(i_cmd_data), .i_cmd_sel(i_cmd_sel),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout)
    );

    always #5 clk = ~clk;

    // One command plus the slave's behaviour for it: stall for the first s
    // cycles of cyc, complete (ack and/or err) in cycle a (counted from 0).
    typedef struct {
        bit          we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          s;
        int          a;
        bit          ack_en;
        bit          err_en;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          tmo;
    } rsp_t;

    typedef struct {
        txn_t t;
        int   cyc_len;
        int   stb_len;
    } bus_t;

    txn_t plan_q[$];
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int rsp_count = 0;
    bit stray = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Reference: the cycle completes only if the slave answers before the
    // watchdog has counted TMO clocks; otherwise it is a timeout.
    function automatic void model(input txn_t t, output rsp_t r, output int cl, output int sl);
        bit done;
        done = (t.ack_en || t.err_en) && (t.a < TMO);
        if (!done) begin
            r.data = 32'h0; r.err = 1; r.tmo = 1;
            cl = TMO;
            sl = imin(t.s, TMO - 1) + 1;
        end else begin
            cl = t.a + 1;
            sl = imin(t.s, t.a) + 1;
            r.tmo = 0;
            if (t.err_en) begin
                r.data = 32'h0; r.err = 1;
            end else begin
                r.data = t.we ? 32'h0 : t.rdata; r.err = 0;
            end
        end
    endfunction

    function automatic txn_t mk(input bit we, input logic [29:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input int s, input int a,
                                input bit ack_en, input bit err_en, input logic [31:0] rdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.sel = sel;
        t.s = s; t.a = a; t.ack_en = ack_en; t.err_en = err_en; t.rdata = rdata;
        return t;
    endfunction

    // Present a command, wait (bounded) for the handshake, queue expectations.
    task automatic issue(input txn_t t, input bit hold);
        int   guard;
        bit   rdy;
        rsp_t r;
        bus_t b;
        i_cmd_valid = 1'b1;
        i_cmd_we    = t.we;
        i_cmd_addr  = t.addr;
        i_cmd_data  = t.wdata;
        i_cmd_sel   = t.sel;
        guard = 0;
        do begin
            @(negedge clk);
            rdy = o_cmd_ready;
            @(posedge clk);
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            chk("cmd_handshake_timeout", 0, 1);
        end else begin
            model(t, r, b.cyc_len, b.stb_len);
            b.t = t;
            plan_q.push_back(t);
            bus_q.push_back(b);
            rsp_q.push_back(r);
        end
        #1;
        if (!hold) i_cmd_valid = 1'b0;
        // Scramble the command bus; the master must ignore it while busy.
        i_cmd_addr = 30'($urandom);
        i_cmd_data = $urandom;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && g < 500) begin
            @(posedge clk);
            g++;
        end
        chk("drain_rsp_pending", 64'(rsp_q.size()), 0);
        chk("drain_bus_pending", 64'(bus_q.size()), 0);
        #1;
    endtask

    // Scripted slave: decodes the plan of the current cycle, otherwise idle.
    initial begin : slave
        txn_t cur;
        bit   have;
        int   n;
        have = 0;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (i_reset || !o_wb_cyc) begin
                have = 0; n = 0;
                i_wb_stall = 1'b0;
                i_wb_ack   = stray;
                i_wb_err   = 1'b0;
                i_wb_data  = $urandom;
            end else begin
                if (!have) begin
                    if (plan_q.size() != 0) cur = plan_q.pop_front();
                    else cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
                    have = 1;
                    n = 0;
                end
                i_wb_stall = (n < cur.s);
                i_wb_ack   = cur.ack_en && (n == cur.a);
                i_wb_err   = cur.err_en && (n == cur.a);
                i_wb_data  = (n == cur.a) ? cur.rdata : $urandom;
                n++;
            end
        end
    end

    // Response monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (!i_reset && o_rsp_valid) begin
            rsp_count++;
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_data", o_rsp_data, e.data);
                chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
                chk("rsp_timeout", 64'(o_rsp_timeout), 64'(e.tmo));
            end
        end
    end

    // Bus monitor: cyc/stb lengths, field stability, gap between cycles.
    bus_t cur_b;
    bit   in_cyc = 0, have_b = 0, stb_dropped = 0, fld_bad = 0;
    int   cyc_len = 0, stb_len = 0, low_len = 0;

    always @(negedge clk) begin
        if (i_reset) begin
            in_cyc = 0; low_len = 0;
        end else if (o_wb_cyc) begin
            if (!in_cyc) begin
                in_cyc = 1;
                chk("cyc_low_gap", 64'(low_len >= 1), 1);
                if (bus_q.size() == 0) begin
                    chk("cyc_unexpected", 1, 0);
                    have_b = 0;
                end else begin
                    cur_b = bus_q.pop_front();
                    have_b = 1;
                end
                cyc_len = 0; stb_len = 0; stb_dropped = 0; fld_bad = 0;
            end
            cyc_len++;
            if (o_wb_stb) begin
                stb_len++;
                if (stb_dropped) fld_bad = 1;
            end else begin
                stb_dropped = 1;
            end
            if (o_cmd_ready) fld_bad = 1;
            if (have_b && (o_wb_we !== cur_b.t.we || o_wb_addr !== cur_b.t.addr ||
                           o_wb_sel !== cur_b.t.sel ||
                           (cur_b.t.we && o_wb_data !== cur_b.t.wdata)))
                fld_bad = 1;
        end else begin
            if (in_cyc) begin
                in_cyc = 0;
                if (have_b) begin
                    chk("cyc_len", 64'(cyc_len), 64'(cur_b.cyc_len));
                    chk("stb_len", 64'(stb_len), 64'(cur_b.stb_len));
                    chk("wb_fields_stable", 64'(fld_bad), 0);
                end
                low_len = 0;
            end
            low_len++;
            chk("stb_without_cyc", 64'(o_wb_stb), 0);
        end
    end

    initial begin : main
        int c0;
        txn_t t;
        int kind;

        repeat (2) @(posedge clk);
        #3 i_reset = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(o_cmd_ready), 1);
        chk("reset_cyc", 64'(o_wb_cyc), 0);
        chk("reset_stb", 64'(o_wb_stb), 0);
        chk("reset_rsp_valid", 64'(o_rsp_valid), 0);
        chk("reset_rsp_data", o_rsp_data, 0);
        @(posedge clk);
        #1;

        // Read at addr 4, one stall cycle then ack with 0x5.
        issue(mk(0, 30'h4, 32'h0, 4'hF, 1, 1, 1, 0, 32'h0000_0005), 0);
        drain();
        // Write, ack three cycles later.
        issue(mk(1, 30'h3, 32'hDEAD_BEEF, 4'hF, 0, 3, 1, 0, 32'h1234_5678), 0);
        drain();
        // err and ack together.
        issue(mk(0, 30'h10, 32'h0, 4'h3, 0, 2, 1, 1, 32'hAAAA_5555), 0);
        drain();
        // Silent slave: timeout, then a stray ack while idle.
        issue(mk(0, 30'h20, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0), 0);
        drain();
        c0 = rsp_count;
        @(negedge clk); stray = 1;
        @(negedge clk); stray = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("stray_ack_no_rsp", 64'(rsp_count), 64'(c0));
        chk("stray_ack_ready", 64'(o_cmd_ready), 1);
        // Watchdog boundary: ack in last allowed cycle, then one too late.
        issue(mk(0, 30'h21, 32'h0, 4'hF, 2, TMO - 1, 1, 0, 32'hCAFE_0001), 0);
        drain();
        issue(mk(0, 30'h22, 32'h0, 4'hF, 0, TMO, 1, 0, 32'hCAFE_0002), 0);
        drain();
        // err alone, ack while still stalled.
        issue(mk(1, 30'h23, 32'h0BAD_F00D, 4'h1, 0, 4, 0, 1, 32'h0), 0);
        drain();
        issue(mk(0, 30'h24, 32'h0, 4'hC, 3, 1, 1, 0, 32'h7777_0000), 0);
        drain();

        // Reset while waiting for the slave.
        issue(mk(0, 30'h30, 32'h0, 4'hF, 0, 30, 1, 0, 32'h0), 0);
        repeat (2) @(posedge clk);
        #4 i_reset = 1'b1;
        #1;
        chk("midreset_cyc", 64'(o_wb_cyc), 0);
        chk("midreset_stb", 64'(o_wb_stb), 0);
        chk("midreset_rsp_valid", 64'(o_rsp_valid), 0);
        chk("midreset_cmd_ready", 64'(o_cmd_ready), 1);
        plan_q.delete(); bus_q.delete(); rsp_q.delete();
        c0 = rsp_count;
        repeat (2) @(posedge clk);
        #3 i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_rsp", 64'(rsp_count), 64'(c0));
        issue(mk(0, 30'h31, 32'h0, 4'hF, 0, 1, 1, 0, 32'h0BB0_0BB0), 0);
        drain();

        // Back-to-back reads with valid held high.
        c0 = rsp_count;
        issue(mk(0, 30'h40, 32'h0, 4'hF, 0, 0, 1, 0, 32'h0000_0041), 1);
        issue(mk(0, 30'h41, 32'h0, 4'hF, 1, 2, 1, 0, 32'h0000_0042), 1);
        issue(mk(0, 30'h42, 32'h0, 4'hF, 0, 1, 1, 0, 32'h0000_0043), 0);
        drain();
        chk("b2b_rsp_count", 64'(rsp_count - c0), 3);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            t = mk(1'($urandom), 30'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 9)),
                   kind >= 2, kind == 1 || kind == 2, $urandom);
            issue(t, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        chk("final_plan_q_empty", 64'(plan_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop against a hung run.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
